// File: rtl/bpred_fetch_ctrl_if.sv
// Core package (BTB geometry and entry type) and the fetch/branch-resolution bundle
// between bpred_fetch_ctrl and the surrounding front-end and EX stage.
package core;
  localparam int BTB_SIZE = 16;

  typedef struct packed {
    logic [31:0] i_addr;
    logic [31:0] target_addr;
  } btb_entry_t;
endpackage

interface bpred_fetch_ctrl_if #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = $clog2(core::BTB_SIZE)
);
  logic                  stall_i;
  logic [ADDR_WIDTH-1:0] btb_raddr_o;
  core::btb_entry_t      btb_entry_i;
  logic [XLEN-1:0]       pc_o;
  logic                  fetch_valid_o;
  logic                  pred_taken_o;
  logic [XLEN-1:0]       pred_target_o;
  logic                  res_valid_i;
  logic [XLEN-1:0]       res_pc_i;
  logic                  res_taken_i;
  logic [XLEN-1:0]       res_target_i;
  logic                  res_pred_taken_i;
  logic [XLEN-1:0]       res_pred_tgt_i;
  logic                  flush_o;

  modport slave (
    input  stall_i, btb_entry_i,
    input  res_valid_i, res_pc_i, res_taken_i, res_target_i,
    input  res_pred_taken_i, res_pred_tgt_i,
    output btb_raddr_o, pc_o, fetch_valid_o, pred_taken_o, pred_target_o, flush_o
  );

  modport master (
    output stall_i, btb_entry_i,
    output res_valid_i, res_pc_i, res_taken_i, res_target_i,
    output res_pred_taken_i, res_pred_tgt_i,
    input  btb_raddr_o, pc_o, fetch_valid_o, pred_taken_o, pred_target_o, flush_o
  );
endinterface

// File: rtl/bpred_fetch_ctrl.sv
// Fetch next-PC generator: fetch PC, 2-bit BHT, BTB lookup, EX resolution and redirect.
// Optional BPRED_PERF_EN adds saturating branch / mispredict counters.
//
// state       | meaning
// ST_INIT     | clearing BHT to weakly not-taken, one entry per cycle; PC held at RESET_PC
// ST_RUN      | normal fetch, PC follows prediction
// ST_REDIRECT | one-cycle front-end flush, PC loaded with resolved PC
module bpred_fetch_ctrl #(
  parameter int              XLEN     = 32,
  parameter int              BHT_SIZE = core::BTB_SIZE,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef BPRED_PERF_EN
  output logic [31:0]             perf_branches_o,
  output logic [31:0]             perf_mispred_o,
`endif
  bpred_fetch_ctrl_if.slave       bus
);

  localparam int ADDR_WIDTH = $clog2(BHT_SIZE);

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic [1:0]            bht_q [BHT_SIZE];

  logic [ADDR_WIDTH-1:0] pc_idx;
  logic [ADDR_WIDTH-1:0] res_idx;
  logic                  btb_hit;
  logic                  pred_taken;
  logic [XLEN-1:0]       pc_plus4;
  logic [XLEN-1:0]       pred_target;
  logic                  res_active;
  logic                  mispredict;
  logic [XLEN-1:0]       redirect_pc;
  logic [1:0]            bht_cur;
  logic [1:0]            bht_trained;

  // ---------------------------------------------------------------- prediction
  assign pc_idx   = pc_q[ADDR_WIDTH+1:2];
  assign pc_plus4 = pc_q + XLEN'(4);
  assign btb_hit  = (bus.btb_entry_i.i_addr == pc_q) && (pc_q != '0);

  // counters are not meaningful until INIT has swept the whole table
  assign pred_taken  = btb_hit && bht_q[pc_idx][1] && (state_q != ST_INIT);
  assign pred_target = pred_taken ? bus.btb_entry_i.target_addr : pc_plus4;

  // ---------------------------------------------------------------- resolution
  assign res_idx     = bus.res_pc_i[ADDR_WIDTH+1:2];
  assign res_active  = bus.res_valid_i && (state_q != ST_INIT);
  assign mispredict  = res_active &&
                       ((bus.res_taken_i != bus.res_pred_taken_i) ||
                        (bus.res_taken_i && (bus.res_target_i != bus.res_pred_tgt_i)));
  assign redirect_pc = bus.res_taken_i ? bus.res_target_i : (bus.res_pc_i + XLEN'(4));

  always_comb begin
    bht_cur     = bht_q[res_idx];
    bht_trained = bht_cur;
    if (bus.res_taken_i) begin
      if (bht_cur != 2'b11) bht_trained = bht_cur + 2'b01;
    end else begin
      if (bht_cur != 2'b00) bht_trained = bht_cur - 2'b01;
    end
  end

  // BHT is a plain storage array; its contents are established by the INIT sweep
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      bht_q[init_cnt_q] <= 2'b01;
    end else if (res_active) begin
      bht_q[res_idx] <= bht_trained;
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '1;
      pc_q       <= RESET_PC;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      pc_q       <= pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    pc_d       = pc_q;

    unique case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q - ADDR_WIDTH'(1);
        if (init_cnt_q == '0) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (mispredict) state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        state_d = mispredict ? ST_REDIRECT : ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    // a mispredict wins over back-pressure: the stalled instruction is wrong-path anyway
    if (mispredict) begin
      pc_d = redirect_pc;
    end else if ((state_q == ST_INIT) || bus.stall_i) begin
      pc_d = pc_q;
    end else begin
      pc_d = pred_target;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign bus.btb_raddr_o   = pc_q[ADDR_WIDTH+1:2];
  assign bus.pc_o          = pc_q;
  assign bus.fetch_valid_o = (state_q == ST_RUN);
  assign bus.flush_o       = (state_q == ST_REDIRECT);
  assign bus.pred_taken_o  = pred_taken;
  assign bus.pred_target_o = pred_target;

`ifdef BPRED_PERF_EN
  logic [31:0] perf_br_q;
  logic [31:0] perf_mp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else begin
      if (res_active && (perf_br_q != '1)) perf_br_q <= perf_br_q + 32'd1;
      if (mispredict && (perf_mp_q != '1)) perf_mp_q <= perf_mp_q + 32'd1;
    end
  end

  assign perf_branches_o = perf_br_q;
  assign perf_mispred_o  = perf_mp_q;
`endif

endmodule

// File: tb/tb_bpred_fetch_ctrl.sv
// Directed bench for bpred_fetch_ctrl: reset/INIT sweep, sequential fetch, BTB+BHT
// prediction, mispredict redirect, stall priority, counter saturation, reset mid-INIT.
module tb_bpred_fetch_ctrl;

  localparam int XLEN = 32;
  localparam int AW   = 4;

  logic clk;
  logic rst_n;

  bpred_fetch_ctrl_if #(.XLEN(XLEN), .ADDR_WIDTH(AW)) bus ();

  bpred_fetch_ctrl #(
    .XLEN     (XLEN),
    .BHT_SIZE (16),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  core::btb_entry_t btb_mem [16];
  assign bus.btb_entry_i = btb_mem[bus.btb_raddr_o];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_res(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
    bus.res_valid_i      = 1'b1;
    bus.res_pc_i         = pc;
    bus.res_taken_i      = taken;
    bus.res_target_i     = tgt;
    bus.res_pred_taken_i = ptk;
    bus.res_pred_tgt_i   = ptgt;
  endtask

  task automatic clear_res();
    bus.res_valid_i = 1'b0;
  endtask

  // 16 cycles with fetch_valid_o low and pc_o at reset value, then RUN
  task automatic wait_init(input string tag);
    for (int i = 0; i < 16; i++) begin
      check_val({tag, "_hold"}, {31'd0, bus.fetch_valid_o, bus.pc_o}, 64'd0);
      step();
    end
    check_val({tag, "_run_fv"}, bus.fetch_valid_o, 1);
    check_val({tag, "_run_pc"}, bus.pc_o, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) btb_mem[i] = '0;
    btb_mem[0] = '{i_addr: 32'h40, target_addr: 32'h100};
    btb_mem[5] = '{i_addr: 32'h14, target_addr: 32'h180};

    rst_n       = 1'b0;
    bus.stall_i = 1'b0;
    drive_res(32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    clear_res();
    repeat (2) @(negedge clk);

    check_val("rst_pc",     bus.pc_o, 32'h0);
    check_val("rst_fv",     bus.fetch_valid_o, 0);
    check_val("rst_flush",  bus.flush_o, 0);
    check_val("rst_ptaken", bus.pred_taken_o, 0);
    check_val("rst_ptgt",   bus.pred_target_o, 32'h4);

    rst_n = 1'b1;
    wait_init("init1");
    step();
    check_val("seq_pc4", bus.pc_o, 32'h4);
    step();
    check_val("seq_pc8", bus.pc_o, 32'h8);

    // taken branch at 0x80 predicted not-taken; also trains BHT[0] to 2
    drive_res(32'h80, 1'b1, 32'h200, 1'b0, 32'h84);
    step();
    clear_res();
    check_val("mp_flush", bus.flush_o, 1);
    check_val("mp_fv",    bus.fetch_valid_o, 0);
    check_val("mp_pc",    bus.pc_o, 32'h200);
    step();
    check_val("mp_flush_end", bus.flush_o, 0);
    check_val("mp_fv_end",    bus.fetch_valid_o, 1);
    check_val("mp_resume",    bus.pc_o, 32'h204);
    check_val("raddr_204",    bus.btb_raddr_o, 4'h1);

    // redirect onto 0x40 where BTB hits and BHT[0]=2
    drive_res(32'h104, 1'b1, 32'h40, 1'b0, 32'h108);
    step();
    clear_res();
    check_val("btb_pc",     bus.pc_o, 32'h40);
    check_val("btb_raddr",  bus.btb_raddr_o, 4'h0);
    check_val("btb_ptaken", bus.pred_taken_o, 1);
    check_val("btb_ptgt",   bus.pred_target_o, 32'h100);
    step();
    check_val("btb_next", bus.pc_o, 32'h100);

    // stall held together with a mispredict: redirect still taken
    bus.stall_i = 1'b1;
    drive_res(32'h108, 1'b1, 32'h40, 1'b0, 32'h10c);
    step();
    clear_res();
    check_val("stmp_pc",    bus.pc_o, 32'h40);
    check_val("stmp_flush", bus.flush_o, 1);
    step();
    check_val("stall_pc", bus.pc_o, 32'h40);
    check_val("stall_fv", bus.fetch_valid_o, 1);

    // 5x taken from 2: saturates at 3, never wraps
    for (int i = 0; i < 5; i++) begin
      drive_res(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
      step();
      check_val("sat_hi_ptaken", bus.pred_taken_o, 1);
      check_val("sat_hi_pc",     bus.pc_o, 32'h40);
    end
    // 5x not taken from 3: 2,1,0,0,0
    for (int i = 0; i < 5; i++) begin
      drive_res(32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
      step();
      check_val("sat_lo_ptaken", bus.pred_taken_o, (i == 0) ? 1 : 0);
    end
    check_val("sat_lo_pc", bus.pc_o, 32'h40);
    drive_res(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    step();
    check_val("from0_ptaken", bus.pred_taken_o, 0);
    // same-cycle train and lookup: old counter visible until the edge
    check_val("nobypass_old", bus.pred_taken_o, 0);
    step();
    clear_res();
    check_val("nobypass_new", bus.pred_taken_o, 1);

    drive_res(32'h14, 1'b1, 32'h180, 1'b1, 32'h180);
    step();
    step();
    clear_res();
    check_val("train5_pc", bus.pc_o, 32'h40);

    // mispredict during REDIRECT reloads PC and stays in REDIRECT
    bus.stall_i = 1'b0;
    drive_res(32'h300, 1'b1, 32'h500, 1'b0, 32'h304);
    step();
    check_val("rr_first_pc",    bus.pc_o, 32'h500);
    check_val("rr_first_flush", bus.flush_o, 1);
    drive_res(32'h600, 1'b0, 32'h0, 1'b1, 32'h700);
    step();
    clear_res();
    check_val("rr_second_pc",    bus.pc_o, 32'h604);
    check_val("rr_second_flush", bus.flush_o, 1);
    check_val("rr_second_fv",    bus.fetch_valid_o, 0);
    step();
    check_val("rr_run_flush", bus.flush_o, 0);
    check_val("rr_run_pc",    bus.pc_o, 32'h608);

    // async reset mid-operation, then a second pulse mid-INIT
    rst_n = 1'b0;
    #1;
    check_val("async_pc", bus.pc_o, 32'h0);
    check_val("async_fv", bus.fetch_valid_o, 0);
    check_val("async_fl", bus.flush_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    drive_res(32'h80, 1'b1, 32'h900, 1'b0, 32'h0);
    step();
    clear_res();
    check_val("init_ignore_pc", bus.pc_o, 32'h0);
    check_val("init_ignore_fl", bus.flush_o, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("init2");

    // every counter back to weakly not-taken: BTB hits at 0x14 and 0x40 fall through
    for (int k = 0; k <= 16; k++) begin
      check_val("walk_pc", bus.pc_o, 32'(4 * k));
      if (k == 5) check_val("walk_idx5_ptaken", bus.pred_taken_o, 0);
      if (k < 16) step();
    end
    bus.stall_i = 1'b1;
    check_val("re0_ptaken", bus.pred_taken_o, 0);
    check_val("re0_ptgt",   bus.pred_target_o, 32'h44);
    drive_res(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    step();
    clear_res();
    check_val("re1_ptaken", bus.pred_taken_o, 1);
    check_val("re1_ptgt",   bus.pred_target_o, 32'h100);
    bus.stall_i = 1'b0;
    step();
    check_val("re1_next", bus.pc_o, 32'h100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
